// File: rtl/acumulador_somatorio.sv
// Saturating running-sum accumulator: adds `valor` on each rising edge of `somar`,
// counts accepted parcels and closes the session at the parcel limit or on saturation.
module acumulador_somatorio #(
    parameter int LARGURA_VALOR = 8,
    parameter int LARGURA_SOMA  = 8,
    parameter int MAX_PARCELAS  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LARGURA_VALOR-1:0] valor,
    input  logic                     somar,
    input  logic                     zerar,
    output logic [LARGURA_SOMA-1:0]  somatorio,
    output logic [3:0]               num_parcelas,
    output logic                     saturado,
    output logic                     encerrado,
    output logic                     ocioso
);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ACUMULANDO = 2'd1,
        ENCERRADO  = 2'd2
    } estado_t;

    localparam int LARGURA_CALC =
        ((LARGURA_VALOR > LARGURA_SOMA) ? LARGURA_VALOR : LARGURA_SOMA) + 1;
    localparam logic [LARGURA_CALC-1:0] SOMA_MAX =
        LARGURA_CALC'({LARGURA_SOMA{1'b1}});
    localparam logic [3:0] LIMITE = 4'(MAX_PARCELAS);

    // Returns {clipped, sum}; the sum pins at all-ones instead of wrapping.
    function automatic logic [LARGURA_SOMA:0] soma_saturada(
        input logic [LARGURA_SOMA-1:0]  acc,
        input logic [LARGURA_VALOR-1:0] v
    );
        logic [LARGURA_CALC-1:0] bruto;
        bruto = LARGURA_CALC'(acc) + LARGURA_CALC'(v);
        if (bruto > SOMA_MAX)
            return {1'b1, {LARGURA_SOMA{1'b1}}};
        return {1'b0, bruto[LARGURA_SOMA-1:0]};
    endfunction

    estado_t                 estado;
    logic                    somar_q;
    logic                    pedido;
    logic                    aceita;
    logic [LARGURA_SOMA:0]   resultado;
    logic                    clipou;
    logic [LARGURA_SOMA-1:0] soma_nova;
    logic [3:0]              parcelas_nova;
    logic                    fim;

    always_comb begin
        pedido        = somar & ~somar_q;
        aceita        = pedido && !zerar && (estado != ENCERRADO);
        resultado     = soma_saturada(somatorio, valor);
        clipou        = resultado[LARGURA_SOMA];
        soma_nova     = resultado[LARGURA_SOMA-1:0];
        parcelas_nova = num_parcelas + 4'd1;
        fim           = clipou || (parcelas_nova == LIMITE);
    end

    // somar_q resets high so a button held through reset release does not add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= OCIOSO;
            somar_q      <= 1'b1;
            somatorio    <= '0;
            num_parcelas <= '0;
            saturado     <= 1'b0;
            encerrado    <= 1'b0;
            ocioso       <= 1'b1;
        end else begin
            somar_q <= somar;
            if (zerar) begin
                estado       <= OCIOSO;
                somatorio    <= '0;
                num_parcelas <= '0;
                saturado     <= 1'b0;
                encerrado    <= 1'b0;
                ocioso       <= 1'b1;
            end else if (aceita) begin
                somatorio    <= soma_nova;
                num_parcelas <= parcelas_nova;
                saturado     <= saturado | clipou;
                ocioso       <= 1'b0;
                if (fim) begin
                    estado    <= ENCERRADO;
                    encerrado <= 1'b1;
                end else begin
                    estado    <= ACUMULANDO;
                    encerrado <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/acumulador_somatorio.md
Name: acumulador_somatorio

Overview:
- Upstream stage of the threshold-signalling block: it builds the 8-bit `somatorio` that the signalling block compares against 99.
- Adds one operand `valor` to a running sum on each rising edge of the `somar` request, which comes from a debounced button level.
- Counts how many operands (parcelas) have been accepted.
- Stops accepting operands when the parcel limit is reached or the sum saturates.
- A synchronous `zerar` request clears the session.

Parameters:
LARGURA_VALOR, 8, width of the input operand `valor`.
LARGURA_SOMA, 8, width of `somatorio`; the sum saturates at 2^LARGURA_SOMA-1.
MAX_PARCELAS, 10, number of accepted operands after which the block enters ENCERRADO; range 1..15.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
valor  input  LARGURA_VALOR  operand; sampled only on an accepted `somar` edge.
somar  input  1  debounced add-request level; its rising edge triggers one addition.
zerar  input  1  synchronous clear request, level-sensitive.
somatorio  output  LARGURA_SOMA  registered running sum.
num_parcelas  output  4  registered count of accepted operands.
saturado  output  1  registered; 1 once the sum has clipped at the maximum.
encerrado  output  1  registered; 1 while the FSM is in ENCERRADO.
ocioso  output  1  registered; 1 while the FSM is in OCIOSO.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - FSM goes to OCIOSO.
  - `somatorio`=0, `num_parcelas`=0, `saturado`=0, `encerrado`=0, `ocioso`=1.
  - Edge-detect register `somar_q`=1, so a button held through reset release produces no addition.
- Edge detect:
  - `somar_q` <= `somar` every cycle.
  - `pedido` = `somar` & !`somar_q`.
  - A level held for N cycles yields exactly one `pedido`.
- Latency: on the clk edge where `pedido`=1 and the add is accepted, `somatorio`, `num_parcelas` and the flags all update at that same edge. Net effect is one cycle from `somar` rising to the new sum being visible.
- Arithmetic:
  - Sum computed as `somatorio` + zero-extended `valor`, at width LARGURA_SOMA+1.
  - If the result exceeds 2^LARGURA_SOMA-1: `somatorio` <= all-ones and `saturado` <= 1.
  - Otherwise `somatorio` <= the low LARGURA_SOMA bits.
  - The sum never wraps.
- `valor`=0 with `pedido` is a valid parcel: `num_parcelas` increments, the sum is unchanged.
- FSM states:
  - OCIOSO:
    - `pedido` -> perform the add, `num_parcelas`=1.
    - Next state is ACUMULANDO, or ENCERRADO if the add saturated or MAX_PARCELAS=1.
  - ACUMULANDO:
    - `pedido` -> perform the add, `num_parcelas`+1.
    - Go to ENCERRADO when the new count equals MAX_PARCELAS or the add saturated.
    - Otherwise stay in ACUMULANDO.
  - ENCERRADO:
    - `pedido` is ignored; all registers hold.
    - Only `zerar` or reset leaves this state.
- `zerar`=1 (any state):
  - Next edge: `somatorio`=0, `num_parcelas`=0, `saturado`=0, FSM -> OCIOSO.
  - `zerar` has priority over a simultaneous `pedido`; that `pedido` is discarded, not deferred.
  - `somar_q` still tracks `somar` during `zerar`. A level still high after `zerar` drops therefore does not add.
- Flag decoding: `encerrado` and `ocioso` are decoded from the registered state and are never 1 simultaneously.
- Async reset asserted mid-operation overrides everything immediately, independent of clk.

Test Plan:
1. Hold `somar`=1 across `rst_n` 0->1, keep it high for 5 cycles -> `somatorio`=0, `num_parcelas`=0, `ocioso`=1.
2. Pulse `somar` with `valor`=40, 40, 19 -> `somatorio`=40, 80, 99, each one cycle after its edge. `num_parcelas`=3, state ACUMULANDO. Also hold `somar` high 4 cycles on one pulse -> only one addition.
3. Add `valor`=200 then `valor`=100 -> `somatorio`=255, `saturado`=1, `encerrado`=1. A further pulse with `valor`=1 -> unchanged 255.
4. Ten pulses with `valor`=1 -> `somatorio`=10, `num_parcelas`=10, `encerrado`=1. An eleventh pulse -> still 10/10.
5. `zerar`=1 in the same cycle as a `somar` rising edge with `valor`=50 -> `somatorio`=0, `num_parcelas`=0, `ocioso`=1. Repeat from ENCERRADO -> same result, and `saturado` cleared.
6. After summing to 120, assert `rst_n`=0 between clk edges -> all outputs reset values immediately, with no clk edge needed.
